// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional perf counters in the top are enabled by HAZARD_PERF_COUNTERS_EN.
package hazard_pkg;

    localparam int unsigned WARM_W = 4;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        S_WARMUP        = 2'd0,
        S_RUN           = 2'd1,
        S_REDIRECT_PEND = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic mem_wb_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } hazard_ctrl_t;

    function automatic hazard_ctrl_t ctrl_flush_all();
        hazard_ctrl_t c;
        c              = '0;
        c.if_id_flush  = 1'b1;
        c.id_ex_flush  = 1'b1;
        c.ex_mem_flush = 1'b1;
        c.mem_wb_flush = 1'b1;
        return c;
    endfunction

    function automatic hazard_ctrl_t ctrl_freeze_all();
        hazard_ctrl_t c;
        c              = '0;
        c.pc_stall     = 1'b1;
        c.if_id_stall  = 1'b1;
        c.id_ex_stall  = 1'b1;
        c.ex_mem_stall = 1'b1;
        c.mem_wb_stall = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/load_use_detector.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detector
    import hazard_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd_addr,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    output logic       load_use
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
    assign rs2_match = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);

    // x0 is hardwired, so a load targeting it never creates a dependency
    assign load_use  = ex_mem_read && (ex_rd_addr != REG_ZERO) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline; perf counters built only
// when HAZARD_PERF_COUNTERS_EN is defined.
//
//   state            | meaning
//   S_WARMUP         | post-reset window, every pipeline register flushed
//   S_RUN            | normal operation, priority mux drives controls
//   S_REDIRECT_PEND  | branch target loaded during an I-miss; in-flight word is stale
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned RESET_FLUSH_CYCLES = 4,
    parameter int unsigned CNT_W              = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IMEM_BUSYWAIT,
    input  logic             DMEM_BUSYWAIT,
    input  logic [4:0]       ID_RS1_ADDR,
    input  logic [4:0]       ID_RS2_ADDR,
    input  logic             ID_USES_RS1,
    input  logic             ID_USES_RS2,
    input  logic             EX_MEM_READ,
    input  logic [4:0]       EX_RD_ADDR,
    input  logic             EX_BRANCH_TAKEN,
    output logic             PC_STALL,
    output logic             IF_ID_STALL,
    output logic             ID_EX_STALL,
    output logic             EX_MEM_STALL,
    output logic             MEM_WB_STALL,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_FLUSH,
    output logic             EX_MEM_FLUSH,
    output logic             MEM_WB_FLUSH,
    output logic [CNT_W-1:0] STALL_CYCLES,
    output logic [CNT_W-1:0] FLUSH_EVENTS
);

    localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(RESET_FLUSH_CYCLES);

    hazard_state_t     state_q;
    hazard_state_t     state_d;
    logic [WARM_W-1:0] warm_q;
    logic [WARM_W-1:0] warm_d;
    logic              load_use;
    logic              running;
    hazard_ctrl_t      ctrl_raw;
    hazard_ctrl_t      ctrl;

    load_use_detector u_load_use_detector (
        .ex_mem_read (EX_MEM_READ),
        .ex_rd_addr  (EX_RD_ADDR),
        .id_rs1_addr (ID_RS1_ADDR),
        .id_rs2_addr (ID_RS2_ADDR),
        .id_uses_rs1 (ID_USES_RS1),
        .id_uses_rs2 (ID_USES_RS2),
        .load_use    (load_use)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_WARMUP;
            warm_q  <= WARM_INIT;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        warm_d   = warm_q;
        ctrl_raw = '0;
        if (RESET) begin
            ctrl_raw = ctrl_flush_all();
        end else begin
            unique case (state_q)
                S_WARMUP: begin
                    ctrl_raw = ctrl_flush_all();
                    warm_d   = warm_q - WARM_W'(1);
                    if (warm_q <= WARM_W'(1)) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN, S_REDIRECT_PEND: begin
                    if (DMEM_BUSYWAIT) begin
                        // EX is frozen, so a taken branch re-presents once the miss clears
                        ctrl_raw = ctrl_freeze_all();
                    end else if (EX_BRANCH_TAKEN) begin
                        ctrl_raw.if_id_flush = 1'b1;
                        ctrl_raw.id_ex_flush = 1'b1;
                        if (IMEM_BUSYWAIT) begin
                            state_d = S_REDIRECT_PEND;
                        end
                    end else if (load_use) begin
                        ctrl_raw.pc_stall    = 1'b1;
                        ctrl_raw.if_id_stall = 1'b1;
                        ctrl_raw.id_ex_flush = 1'b1;
                    end else if (IMEM_BUSYWAIT) begin
                        ctrl_raw.pc_stall    = 1'b1;
                        ctrl_raw.if_id_flush = 1'b1;
                    end else if (state_q == S_REDIRECT_PEND) begin
                        // drop the wrong-path word that just arrived, then refetch the target
                        ctrl_raw.pc_stall    = 1'b1;
                        ctrl_raw.if_id_flush = 1'b1;
                        state_d              = S_RUN;
                    end
                end
                default: begin
                    ctrl_raw = ctrl_flush_all();
                    state_d  = S_WARMUP;
                    warm_d   = WARM_INIT;
                end
            endcase
        end
    end

    always_comb begin
        ctrl              = ctrl_raw;
        ctrl.if_id_stall  = ctrl_raw.if_id_stall  & ~ctrl_raw.if_id_flush;
        ctrl.id_ex_stall  = ctrl_raw.id_ex_stall  & ~ctrl_raw.id_ex_flush;
        ctrl.ex_mem_stall = ctrl_raw.ex_mem_stall & ~ctrl_raw.ex_mem_flush;
        ctrl.mem_wb_stall = ctrl_raw.mem_wb_stall & ~ctrl_raw.mem_wb_flush;
    end

    assign PC_STALL     = ctrl.pc_stall;
    assign IF_ID_STALL  = ctrl.if_id_stall;
    assign ID_EX_STALL  = ctrl.id_ex_stall;
    assign EX_MEM_STALL = ctrl.ex_mem_stall;
    assign MEM_WB_STALL = ctrl.mem_wb_stall;
    assign IF_ID_FLUSH  = ctrl.if_id_flush;
    assign ID_EX_FLUSH  = ctrl.id_ex_flush;
    assign EX_MEM_FLUSH = ctrl.ex_mem_flush;
    assign MEM_WB_FLUSH = ctrl.mem_wb_flush;

    assign running = !RESET && ((state_q == S_RUN) || (state_q == S_REDIRECT_PEND));

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (running && ctrl.pc_stall) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (running && ctrl.id_ex_flush) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign STALL_CYCLES = stall_cnt_q;
    assign FLUSH_EVENTS = flush_cnt_q;
`else
    logic unused_running;
    assign unused_running = running;
    assign STALL_CYCLES   = '0;
    assign FLUSH_EVENTS   = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: directed scenarios then random traffic.
module tb_pipeline_hazard_controller;

    localparam int unsigned N_WARM = 4;
    localparam int unsigned CNT_W  = 32;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             IMEM_BUSYWAIT, DMEM_BUSYWAIT;
    logic [4:0]       ID_RS1_ADDR, ID_RS2_ADDR, EX_RD_ADDR;
    logic             ID_USES_RS1, ID_USES_RS2, EX_MEM_READ, EX_BRANCH_TAKEN;
    logic             PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_STALL;
    logic             IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH;
    logic [CNT_W-1:0] STALL_CYCLES, FLUSH_EVENTS;

    pipeline_hazard_controller #(.RESET_FLUSH_CYCLES(N_WARM), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
        .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .EX_MEM_READ(EX_MEM_READ), .EX_RD_ADDR(EX_RD_ADDR),
        .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN),
        .PC_STALL(PC_STALL), .IF_ID_STALL(IF_ID_STALL), .ID_EX_STALL(ID_EX_STALL),
        .EX_MEM_STALL(EX_MEM_STALL), .MEM_WB_STALL(MEM_WB_STALL),
        .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH),
        .EX_MEM_FLUSH(EX_MEM_FLUSH), .MEM_WB_FLUSH(MEM_WB_FLUSH),
        .STALL_CYCLES(STALL_CYCLES), .FLUSH_EVENTS(FLUSH_EVENTS)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [8:0]  ctl;      // {pc_s, ifid_s, idex_s, exmem_s, memwb_s, ifid_f, idex_f, exmem_f, memwb_f}
        bit          cnt_valid;
        logic [31:0] stall_cnt;
        logic [31:0] flush_cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model: cycles left in warm-up, whether a redirect is owed, event tallies.
    int          warm_left = 0;
    bit          redirect_owed = 0;
    bit          seen_reset = 0;
    int unsigned n_stall = 0;
    int unsigned n_flush = 0;

    task automatic drive(input bit rst, input bit imem, input bit dmem, input bit br,
                         input bit ld, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input bit u1, input bit u2);
        exp_t e;
        bit   pc_s, ifid_s, idex_s, exmem_s, memwb_s, ifid_f, idex_f, exmem_f, memwb_f;
        bit   hazard;
        @(posedge CLK);
        #1;
        RESET = rst; IMEM_BUSYWAIT = imem; DMEM_BUSYWAIT = dmem; EX_BRANCH_TAKEN = br;
        EX_MEM_READ = ld; EX_RD_ADDR = rd; ID_RS1_ADDR = rs1; ID_RS2_ADDR = rs2;
        ID_USES_RS1 = u1; ID_USES_RS2 = u2;

        {pc_s, ifid_s, idex_s, exmem_s, memwb_s, ifid_f, idex_f, exmem_f, memwb_f} = '0;
        hazard = ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
`ifdef HAZARD_PERF_COUNTERS_EN
        e.cnt_valid = seen_reset;
        e.stall_cnt = n_stall;
        e.flush_cnt = n_flush;
`else
        e.cnt_valid = 1'b1;
        e.stall_cnt = 0;
        e.flush_cnt = 0;
`endif
        if (rst) begin
            {ifid_f, idex_f, exmem_f, memwb_f} = 4'b1111;
            warm_left = N_WARM; redirect_owed = 0; n_stall = 0; n_flush = 0; seen_reset = 1;
        end else if (warm_left > 0) begin
            {ifid_f, idex_f, exmem_f, memwb_f} = 4'b1111;
            warm_left--;
        end else begin
            if (dmem) begin
                {pc_s, ifid_s, idex_s, exmem_s, memwb_s} = 5'b11111;
            end else if (br) begin
                ifid_f = 1; idex_f = 1;
                if (imem) redirect_owed = 1;
            end else if (hazard) begin
                pc_s = 1; ifid_s = 1; idex_f = 1;
            end else if (imem) begin
                pc_s = 1; ifid_f = 1;
            end else if (redirect_owed) begin
                pc_s = 1; ifid_f = 1; redirect_owed = 0;
            end
            n_stall += 32'(pc_s);
            n_flush += 32'(idex_f);
        end
        e.ctl = {pc_s, ifid_s, idex_s, exmem_s, memwb_s, ifid_f, idex_f, exmem_f, memwb_f};
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
    initial begin : monitor
        exp_t        e;
        logic [8:0]  got;
        forever begin
            @(negedge CLK);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = {PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_STALL,
                       IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH};
                checks++;
                if (got !== e.ctl) begin
                    errors++;
                    $display("FAIL ctl t=%0t got=%b exp=%b", $time, got, e.ctl);
                end
                if (e.cnt_valid) begin
                    checks += 2;
                    if (STALL_CYCLES !== e.stall_cnt) begin
                        errors++;
                        $display("FAIL stall_cycles t=%0t got=%0d exp=%0d", $time, STALL_CYCLES, e.stall_cnt);
                    end
                    if (FLUSH_EVENTS !== e.flush_cnt) begin
                        errors++;
                        $display("FAIL flush_events t=%0t got=%0d exp=%0d", $time, FLUSH_EVENTS, e.flush_cnt);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bit imem_r, ld_r;
        RESET = 1; IMEM_BUSYWAIT = 0; DMEM_BUSYWAIT = 0; EX_BRANCH_TAKEN = 0;
        EX_MEM_READ = 0; EX_RD_ADDR = 0; ID_RS1_ADDR = 0; ID_RS2_ADDR = 0;
        ID_USES_RS1 = 0; ID_USES_RS2 = 0;

        // reset and warm-up window
        drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(6);
        // load-use via rs2, then same with x0 destination
        drive(0, 0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1);
        idle(1);
        drive(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 1);
        idle(1);
        // plain taken branch
        drive(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(1);
        // taken branch during an I-miss lasting three more cycles
        drive(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(2);
        // D-miss beats load-use and branch; branch re-presents afterwards
        drive(0, 0, 1, 1, 1, 5'd7, 5'd7, 5'd0, 1, 0);
        drive(0, 0, 1, 1, 1, 5'd7, 5'd7, 5'd0, 1, 0);
        drive(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(2);
        // counter scenario: 10 load-use stalls, 3 taken branches from a fresh reset
        drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(N_WARM + 1);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd9, 1, 0);
            idle(1);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            idle(1);
        end
        idle(2);
        // random traffic with bursty I-misses and a narrow register range
        imem_r = 0;
        for (int i = 0; i < 1500; i++) begin
            imem_r = imem_r ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
            ld_r   = $urandom_range(0, 1) == 1;
            drive($urandom_range(0, 99) == 0, imem_r, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 99) < 15, ld_r,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives hold and bubble controls for the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) from four sources: memory busywaits, load-use hazards, taken branches/jumps, and post-reset warm-up.
- Combinational controls are qualified by a small FSM that tracks a pending redirect across an instruction-memory miss and a post-reset flush window.

Parameters:
- RESET_FLUSH_CYCLES, 4: cycles of all-register flush after RESET deasserts (1..15).
- CNT_W, 32: width of the performance counters (optional feature).

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset, sampled on posedge CLK.
- IMEM_BUSYWAIT  in  1  instruction cache miss in progress.
- DMEM_BUSYWAIT  in  1  data cache miss in progress.
- ID_RS1_ADDR  in  5  rs1 index of the instruction in ID.
- ID_RS2_ADDR  in  5  rs2 index of the instruction in ID.
- ID_USES_RS1  in  1  ID instruction reads rs1.
- ID_USES_RS2  in  1  ID instruction reads rs2.
- EX_MEM_READ  in  1  instruction in EX is a load.
- EX_RD_ADDR  in  5  destination of the instruction in EX.
- EX_BRANCH_TAKEN  in  1  branch/jump resolved taken in EX this cycle.
- PC_STALL  out  1  hold the PC.
- IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_STALL  out  1 each  hold the register.
- IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH  out  1 each  load a NOP/bubble.
- STALL_CYCLES, FLUSH_EVENTS  out  CNT_W each  counters (only with the optional feature).

Behaviour:
- FSM states: S_WARMUP, S_RUN, S_REDIRECT_PEND.
- RESET=1: next state S_WARMUP, warm-up counter loaded with RESET_FLUSH_CYCLES, counters cleared to 0.
- While RESET=1 or in S_WARMUP: all *_FLUSH=1, all *_STALL=0, PC_STALL=0.
- S_WARMUP: counter decrements each cycle; at 0 the FSM moves to S_RUN. The flush pattern therefore lasts exactly RESET_FLUSH_CYCLES cycles after the first posedge with RESET=0.
- Outputs are combinational from the current state and current inputs, valid before the posedge at which the registers sample. All outputs not listed under a rule are 0.
- Rule priority in S_RUN / S_REDIRECT_PEND (highest first):
  1. DMEM_BUSYWAIT=1: all five stalls = 1 (full freeze); no flushes; the FSM holds state; taken-branch capture is suppressed, because EX is frozen and the branch re-presents.
  2. EX_BRANCH_TAKEN=1: IF_ID_FLUSH=1 and ID_EX_FLUSH=1. If IMEM_BUSYWAIT=1 as well, PC_STALL=0 (PC loads the target) and the next state is S_REDIRECT_PEND.
  3. Load-use: EX_MEM_READ=1 and EX_RD_ADDR!=0 and ((ID_USES_RS1 and rs1==EX_RD_ADDR) or (ID_USES_RS2 and rs2==EX_RD_ADDR)). Response: PC_STALL=1, IF_ID_STALL=1, ID_EX_FLUSH=1 (exactly one bubble per hazard instance).
  4. IMEM_BUSYWAIT=1: PC_STALL=1, IF_ID_FLUSH=1 (bubble into ID while the downstream stages drain).
- S_REDIRECT_PEND: the in-flight fetch is wrong-path. While IMEM_BUSYWAIT=1, rule 4 applies. On the first cycle with IMEM_BUSYWAIT=0: IF_ID_FLUSH=1 and PC_STALL=1 (discard the stale word, then refetch the target); next state S_RUN.
- A new taken branch while in S_REDIRECT_PEND: apply rule 2 and stay in S_REDIRECT_PEND.
- A stall and a flush are never both asserted on the same register; flush wins.
- Mid-operation RESET overrides everything on the next posedge.

Optional Feature:
- Macro: HAZARD_PERF_COUNTERS_EN.
- Defined:
  - STALL_CYCLES increments on each S_RUN/S_REDIRECT_PEND cycle with PC_STALL=1.
  - FLUSH_EVENTS increments on each cycle with ID_EX_FLUSH=1 outside warm-up.
  - Both wrap at 2^CNT_W and clear on RESET.
- Undefined: both ports tied to 0 and no counter flops are built.

Decomposition:
- Shared package (hazard_pkg): state encoding constants S_WARMUP=2'd0, S_RUN=2'd1, S_REDIRECT_PEND=2'd2; REG_ZERO=5'd0.
- One natural sub-module: load_use_detector (purely combinational comparator producing the load-use hazard flag).
- FSM, priority mux and counters stay in the top module.

Test Plan:
- Reset: RESET high 2 cycles, then low, RESET_FLUSH_CYCLES=4 -> all flushes=1 for exactly 4 cycles; S_RUN on cycle 5; counters=0.
- Load-use: EX_MEM_READ=1, EX_RD_ADDR=5, ID_RS2_ADDR=5, ID_USES_RS2=1 -> PC_STALL=1, IF_ID_STALL=1, ID_EX_FLUSH=1 for one cycle. Same stimulus with EX_RD_ADDR=0 -> no stall.
- Branch: EX_BRANCH_TAKEN=1 with no busywaits -> IF_ID_FLUSH=1 and ID_EX_FLUSH=1 for one cycle; PC_STALL=0.
- Branch during I-miss: EX_BRANCH_TAKEN=1 while IMEM_BUSYWAIT=1 for 3 more cycles -> S_REDIRECT_PEND; on the busywait fall, IF_ID_FLUSH=1 and PC_STALL=1 for one cycle, then S_RUN.
- D-miss precedence: DMEM_BUSYWAIT=1 concurrent with a load-use condition and EX_BRANCH_TAKEN=1 -> all five stalls=1 and zero flushes; after DMEM_BUSYWAIT falls, the branch flush fires.
- Counters (macro on): 10 load-use stalls plus 3 taken branches -> STALL_CYCLES=10, FLUSH_EVENTS=13.
